uart_tx_core: RTL and testbench

Serial transmit engine behind the memory-mapped UART register block.
- Accepts a byte when the CPU writes THR, holds it in a one-entry holding register, and serialises it on txd.
- Frame format is asynchronous start/data/parity/stop, taken from the LCR fields.
- Returns the LSR THRE/TEMT status bits and a THR-empty interrupt pulse to the register block.

---
 rtl/uart_tx_core_pkg.sv | 38 +++
 rtl/uart_tx_core_if.sv | 13 +
 rtl/uart_baud_timer.sv | 41 ++++
 rtl/uart_tx_core.sv | 121 ++++++++++++
 tb/tb_uart_tx_core.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_core_pkg.sv
// Shared UART constants and types: LCR/LSR bit positions, TX FSM encodings,
// per-frame configuration snapshot.
package uart_tx_core_pkg;

  // LCR field positions (also used by the register block)
  localparam int LCR_WLS_LO = 0;
  localparam int LCR_WLS_HI = 1;
  localparam int LCR_STB    = 2;
  localparam int LCR_PEN    = 3;
  localparam int LCR_EPS    = 4;
  localparam int LCR_BC     = 6;

  // LSR status bit positions
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Frame format captured at the THR->shifter transfer
  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
  } frame_cfg_t;

  // Index of the last data bit for a word-length code (5..8 bits -> 4..7)
  function automatic logic [2:0] last_data_idx(input logic [1:0] wls);
    return {1'b0, wls} + 3'd4;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// THR write / LSR status bundle between the register block and the TX core.
interface uart_tx_core_if #(
  parameter int UART_LEN = 8
);
  logic                thr_wen;
  logic [UART_LEN-1:0] thr_wdata;
  logic                lsr_thre;
  logic                lsr_temt;
  logic                thre_intr;

  modport master (output thr_wen, thr_wdata, input lsr_thre, lsr_temt, thre_intr);
  modport slave  (input thr_wen, thr_wdata, output lsr_thre, lsr_temt, thre_intr);
endinterface

// File: rtl/uart_baud_timer.sv
// Bit-period timer: latches the divisor at frame start and counts
// OVERSAMPLE*div clocks per bit; half_bit_end marks the mid-bit point.
module uart_baud_timer #(
  parameter int DIV_LEN    = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clr,
  input  logic               run,
  input  logic [DIV_LEN-1:0] divisor,
  output logic               bit_end,
  output logic               half_bit_end
);
  // Extra bits so OVERSAMPLE*0xFFFF cannot overflow
  localparam int CNT_W = DIV_LEN + $clog2(OVERSAMPLE);

  logic [DIV_LEN-1:0] div_q;
  logic [CNT_W-1:0]   cnt, term, half_term;

  assign term         = CNT_W'(OVERSAMPLE) * CNT_W'(div_q) - CNT_W'(1);
  assign half_term    = CNT_W'(OVERSAMPLE / 2) * CNT_W'(div_q) - CNT_W'(1);
  assign bit_end      = run && (cnt == term);
  assign half_bit_end = run && (cnt == half_term);

  // Divisor capture and free-running bit counter, wrapping at each bit end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      div_q <= divisor;
      cnt   <= '0;
    end else if (clr || !run || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/uart_tx_core.sv
// UART transmit engine: one-entry THR, start/data/parity/stop serialiser,
// LSR THRE/TEMT status and THR-empty interrupt pulse.
module uart_tx_core
  import uart_tx_core_pkg::*;
#(
  parameter int UART_LEN   = 8,
  parameter int DIV_LEN    = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_core_if.slave      bus,
  input  logic [DIV_LEN-1:0] divisor,
  input  logic [1:0]         lcr_wls,
  input  logic               lcr_stb,
  input  logic               lcr_pen,
  input  logic               lcr_eps,
  input  logic               lcr_bc,
  output logic               txd
);
  localparam int IDX_W = $clog2(UART_LEN);

  tx_state_e           state, state_nxt;
  frame_cfg_t          cfg_q;
  logic [UART_LEN-1:0] thr_q, shifter, par_mask;
  logic [IDX_W-1:0]    bit_idx, last_idx;
  logic                thr_full, thr_full_q, stop_cnt;
  logic                xfer, bit_end, half_bit_end, frame_done, fsm_txd, par_bit;

  assign xfer     = (state == ST_IDLE) && thr_full && (divisor != '0);
  assign last_idx = IDX_W'(last_data_idx(cfg_q.wls));

  uart_baud_timer #(.DIV_LEN(DIV_LEN), .OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .load         (xfer),
    .clr          (frame_done),
    .run          (state != ST_IDLE),
    .divisor      (divisor),
    .bit_end      (bit_end),
    .half_bit_end (half_bit_end)
  );

  // Parity covers only the bits actually sent for this word length
  always_comb begin
    par_mask = '0;
    for (int i = 0; i < UART_LEN; i++)
      par_mask[i] = (i <= int'(cfg_q.wls) + 4);
  end
  assign par_bit = ^(shifter & par_mask);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and raw serial level
  always_comb begin
    state_nxt  = state;
    fsm_txd    = 1'b1;
    frame_done = 1'b0;
    case (state)
      ST_IDLE:   if (xfer) state_nxt = ST_START;
      ST_START: begin
        fsm_txd = 1'b0;
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        fsm_txd = shifter[bit_idx];
        if (bit_end && bit_idx == last_idx)
          state_nxt = cfg_q.pen ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        fsm_txd = cfg_q.eps ? par_bit : ~par_bit;
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Second stop period is a full bit, or half a bit for 5-bit words
        if (!cfg_q.stb)    frame_done = bit_end;
        else if (stop_cnt) frame_done = (cfg_q.wls == 2'd0) ? half_bit_end : bit_end;
        if (frame_done) state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // THR, shifter, frame config snapshot and bit/stop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q      <= '0;
      thr_full   <= 1'b0;
      thr_full_q <= 1'b0;
      shifter    <= '0;
      cfg_q      <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      // A write racing the transfer refills THR, so it stays full
      if (bus.thr_wen) thr_q <= bus.thr_wdata;
      thr_full   <= bus.thr_wen || (thr_full && !xfer);
      thr_full_q <= thr_full;
      if (xfer) begin
        shifter  <= thr_q;
        cfg_q    <= '{wls: lcr_wls, stb: lcr_stb, pen: lcr_pen, eps: lcr_eps};
        bit_idx  <= '0;
        stop_cnt <= 1'b0;
      end else begin
        if (state == ST_START) bit_idx <= '0;
        else if (state == ST_DATA && bit_end) bit_idx <= bit_idx + IDX_W'(1);
        if (state == ST_STOP && bit_end) stop_cnt <= 1'b1;
      end
    end
  end

  // Outputs held at their idle values while reset is asserted; break only hits txd
  assign txd           = rst || (!lcr_bc && fsm_txd);
  assign bus.lsr_thre  = rst || !thr_full;
  assign bus.lsr_temt  = rst || (!thr_full && state == ST_IDLE);
  assign bus.thre_intr = !rst && !thr_full && thr_full_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: reset, 8N1 frame, parity, 5-bit/1.5 stop,
// back-to-back, THR overwrite with divisor 0, break and mid-frame reset.
module tb_uart_tx_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] divisor;
  logic [1:0]  lcr_wls;
  logic        lcr_stb, lcr_pen, lcr_eps, lcr_bc;
  logic        txd;
  int          checks = 0;
  int          failures = 0;
  int          intr_cnt = 0;

  uart_tx_core_if #(.UART_LEN(8)) bus ();

  uart_tx_core #(.UART_LEN(8), .DIV_LEN(16), .OVERSAMPLE(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .divisor (divisor),
    .lcr_wls (lcr_wls),
    .lcr_stb (lcr_stb),
    .lcr_pen (lcr_pen),
    .lcr_eps (lcr_eps),
    .lcr_bc  (lcr_bc),
    .txd     (txd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.thre_intr === 1'b1) intr_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drive a THR write for one edge; returns at the negedge after it
  task automatic strobe(input logic [7:0] b);
    bus.thr_wen   = 1'b1;
    bus.thr_wdata = b;
    @(negedge clk);
    bus.thr_wen = 1'b0;
  endtask

  task automatic wait_txd_low(input string nm, input int maxc, output int n);
    n = 0;
    while (txd !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (txd !== 1'b0) begin
      failures++;
      $display("FAIL %s_start_timeout txd=%b after %0d clocks, required 0", nm, txd, n);
    end
  endtask

  // Called at the first sample of the start bit; returns at the first sample after stop
  task automatic check_frame(input string nm, input logic [7:0] b, input int nd,
                             input bit pen, input bit eps, input int stop_clk, input int div,
                             input bit do_wr, input logic [7:0] nxt, input bit exp_idle);
    int bclk, total, idx, errs, terr, herr, first;
    logic ex, p;
    logic [7:0] m;
    bclk  = 16 * div;
    total = bclk * (1 + nd + (pen ? 1 : 0)) + stop_clk;
    m     = 8'hFF >> (8 - nd);
    p     = ^(b & m);
    errs = 0; terr = 0; herr = 0; first = -1;
    for (int k = 0; k < total; k++) begin
      idx = k / bclk;
      if (idx == 0)                  ex = 1'b0;
      else if (idx <= nd)            ex = b[idx-1];
      else if (pen && idx == nd + 1) ex = eps ? p : ~p;
      else                           ex = 1'b1;
      if (txd !== ex) begin
        errs++;
        if (first < 0) first = k;
      end
      if (bus.lsr_temt !== 1'b0) terr++;
      if (k > 0 && bus.lsr_thre !== (do_wr ? 1'b0 : 1'b1)) herr++;
      if (do_wr && k == 0) begin bus.thr_wen = 1'b1; bus.thr_wdata = nxt; end
      if (do_wr && k == 1) bus.thr_wen = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL %s_bits txd mismatches=%0d first at clock %0d, required 0", nm, errs, first);
    end
    checks++;
    if (terr != 0) begin
      failures++;
      $display("FAIL %s_temt_busy temt high on %0d clocks in frame, required 0", nm, terr);
    end
    checks++;
    if (herr != 0) begin
      failures++;
      $display("FAIL %s_thre thre wrong on %0d clocks in frame, required 0", nm, herr);
    end
    checks++;
    if (txd !== 1'b1 || bus.lsr_temt !== exp_idle) begin
      failures++;
      $display("FAIL %s_end txd=%b temt=%b, required txd=1 temt=%b", nm, txd, bus.lsr_temt, exp_idle);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; divisor = 16'd1; lcr_wls = 2'd3; lcr_stb = 0; lcr_pen = 0; lcr_eps = 0; lcr_bc = 0;
    bus.thr_wen = 0; bus.thr_wdata = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, bus.lsr_thre, bus.lsr_temt, bus.thre_intr} !== 4'b1110) begin
      failures++;
      $display("FAIL reset_during txd/thre/temt/intr=%b%b%b%b, required 1110",
               txd, bus.lsr_thre, bus.lsr_temt, bus.thre_intr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({txd, bus.lsr_thre, bus.lsr_temt, bus.thre_intr} !== 4'b1110) begin
      failures++;
      $display("FAIL reset_after txd/thre/temt/intr=%b%b%b%b, required 1110",
               txd, bus.lsr_thre, bus.lsr_temt, bus.thre_intr);
    end
  endtask

  task automatic test_basic;
    strobe(8'h55);
    checks++;
    if (txd !== 1'b1 || bus.lsr_thre !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold txd=%b thre=%b one edge after write, required txd=1 thre=0", txd, bus.lsr_thre);
    end
    @(negedge clk);
    checks++;
    if (txd !== 1'b0 || bus.lsr_thre !== 1'b1 || bus.thre_intr !== 1'b1) begin
      failures++;
      $display("FAIL basic_xfer txd=%b thre=%b intr=%b two edges after write, required 0 1 1",
               txd, bus.lsr_thre, bus.thre_intr);
    end
    check_frame("basic", 8'h55, 8, 0, 0, 16, 1, 0, 8'h00, 1);
  endtask

  task automatic test_parity;
    int n;
    lcr_wls = 2'd3; lcr_pen = 1; lcr_eps = 1;
    strobe(8'h07);
    wait_txd_low("par_even", 10, n);
    check_frame("par_even", 8'h07, 8, 1, 1, 16, 1, 0, 8'h00, 1);
    lcr_eps = 0;
    strobe(8'h07);
    wait_txd_low("par_odd", 10, n);
    check_frame("par_odd", 8'h07, 8, 1, 0, 16, 1, 0, 8'h00, 1);
    lcr_pen = 0;
  endtask

  task automatic test_len_stop;
    int n;
    lcr_wls = 2'd0; lcr_stb = 1; divisor = 16'd2;
    strobe(8'h1F);
    wait_txd_low("len5", 10, n);
    check_frame("len5", 8'h1F, 5, 0, 0, 48, 2, 0, 8'h00, 1);
    lcr_wls = 2'd3; lcr_stb = 0; divisor = 16'd1;
  endtask

  task automatic test_back_to_back;
    int base;
    base = intr_cnt;
    strobe(8'hA5);
    @(negedge clk);
    checks++;
    if (txd !== 1'b0 || bus.lsr_thre !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_start txd=%b thre=%b, required 0 1", txd, bus.lsr_thre);
    end
    check_frame("b2b_a5", 8'hA5, 8, 0, 0, 16, 1, 1, 8'h3C, 0);
    checks++;
    if (bus.lsr_thre !== 1'b0) begin
      failures++;
      $display("FAIL b2b_thre_pending thre=%b at end of first stop, required 0", bus.lsr_thre);
    end
    @(negedge clk);
    checks++;
    if (txd !== 1'b0 || bus.lsr_thre !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap txd=%b thre=%b cycle after first stop, required 0 1", txd, bus.lsr_thre);
    end
    check_frame("b2b_3c", 8'h3C, 8, 0, 0, 16, 1, 0, 8'h00, 1);
    checks++;
    if (intr_cnt - base != 2) begin
      failures++;
      $display("FAIL b2b_intr pulses=%0d, required 2", intr_cnt - base);
    end
  endtask

  task automatic test_overwrite_div0;
    int errs, n;
    divisor = 16'd0;
    strobe(8'h11);
    strobe(8'h22);
    errs = 0;
    repeat (40) begin
      if (txd !== 1'b1 || bus.lsr_thre !== 1'b0) errs++;
      @(negedge clk);
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL div0_hold wrong txd/thre on %0d clocks, required 0", errs);
    end
    divisor = 16'd3;
    wait_txd_low("div0_release", 10, n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL div0_release_lat latency=%0d, required 1", n);
    end
    check_frame("ovw", 8'h22, 8, 0, 0, 48, 3, 0, 8'h00, 1);
    divisor = 16'd1;
  endtask

  task automatic test_break;
    int n, errs;
    strobe(8'hFF);
    wait_txd_low("brk", 10, n);
    repeat (20) @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin
      failures++;
      $display("FAIL brk_pre txd=%b in data, required 1", txd);
    end
    lcr_bc = 1'b1;
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b0 || bus.lsr_thre !== 1'b1) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL brk_hold wrong txd/thre on %0d clocks, required 0", errs);
    end
    lcr_bc = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1) begin
      failures++;
      $display("FAIL brk_off txd=%b after clearing break, required 1", txd);
    end
    n = 0;
    while (bus.lsr_temt !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 120) begin
      failures++;
      $display("FAIL brk_frame_len clocks to temt=%0d, required 120", n);
    end
  endtask

  task automatic test_mid_reset;
    int n, errs;
    strobe(8'h00);
    wait_txd_low("mrst", 10, n);
    repeat (30) @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin
      failures++;
      $display("FAIL mrst_pre txd=%b in data, required 0", txd);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({txd, bus.lsr_thre, bus.lsr_temt, bus.thre_intr} !== 4'b1110) begin
      failures++;
      $display("FAIL mrst_after txd/thre/temt/intr=%b%b%b%b, required 1110",
               txd, bus.lsr_thre, bus.lsr_temt, bus.thre_intr);
    end
    errs = 0;
    repeat (40) begin
      @(negedge clk);
      if (txd !== 1'b1 || bus.lsr_temt !== 1'b1 || bus.thre_intr !== 1'b0) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL mrst_abort frame activity on %0d clocks after reset, required 0", errs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_len_stop();
    test_back_to_back();
    test_overwrite_div0();
    test_break();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
